// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//   Quad-I/O fast-read (opcode CMD_QREAD) flash target. The system clock is
//   also the serial clock; every input is sampled on the rising edge.
//   Transaction: 8 opcode bits on io0, 6 address nibbles, 2 mode nibbles,
//   DUMMY_CYCLES dummy clocks, then read data streamed high nibble first
//   until csb rises. Bytes are fetched from an external store through a
//   one-cycle mem_rd strobe; mem_rdata returns one cycle later.
//
// Ports
//   clk        clock / serial clock
//   rst_n      asynchronous active-low reset
//   csb        chip select, active low
//   io_in      sampled QSPI lines (io0 = bit 0)
//   io_out     nibble driven toward the initiator
//   io_oe      per-line output enable (all four bits equal)
//   mem_rd     read strobe to the byte store
//   mem_addr   byte address qualified by mem_rd
//   mem_rdata  byte returned one cycle after mem_rd
//   busy       high whenever the FSM is not idle
//   err        sticky unsupported-opcode flag
//
// Build option
//   QSPI_RESP_XIP_EN  enables continuous-read (XIP): a mode byte with bits
//   [5:4] = 2'b10 lets the next transaction start directly at the address.
module qspi_flash_responder #(
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_QREAD    = 8'hEB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csb,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

  // The first fetch must land one clock before the last dummy clock so the
  // high nibble is on the pins right after it. With two dummy clocks that
  // fetch already happens on the last mode clock.
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  localparam logic [3:0] RD_CNT     = 4'(DUMMY_CYCLES - 3);
  localparam bit         RD_IN_MODE = (DUMMY_CYCLES == 2);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        armed, armed_n;
  logic        rd_n;
  logic [23:0] addr_n;
  logic [3:0]  out_n;
  logic        err_n;
  logic        load_lo;

  logic [6:0]  cmd_sh;
  logic [23:0] addr_sh;
  logic [3:0]  lo_q;
`ifdef QSPI_RESP_XIP_EN
  logic        xip, xip_n;
  logic [1:0]  mode_bits;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      armed    <= 1'b0;
      io_out   <= 4'h0;
      mem_rd   <= 1'b0;
      mem_addr <= 24'h0;
      err      <= 1'b0;
`ifdef QSPI_RESP_XIP_EN
      xip      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      armed    <= armed_n;
      io_out   <= out_n;
      mem_rd   <= rd_n;
      mem_addr <= addr_n;
      err      <= err_n;
`ifdef QSPI_RESP_XIP_EN
      xip      <= xip_n;
`endif
    end
  end

  // Shift/capture registers carry no reset: the FSM only consumes them after
  // they have been completely refilled within the current transaction.
  always_ff @(posedge clk) begin
    cmd_sh <= {cmd_sh[5:0], io_in[0]};
    // IDLE shifting supplies the first nibble when XIP skips the opcode.
    if (state == IDLE || state == ADDR) addr_sh <= {addr_sh[19:0], io_in};
    if (load_lo) lo_q <= mem_rdata[3:0];
`ifdef QSPI_RESP_XIP_EN
    if (state == MODE && cnt == 4'd0) mode_bits <= io_in[1:0];
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 4'd1;
    // Decoding is only allowed after csb has been seen high since reset.
    armed_n = armed | csb;
    rd_n    = 1'b0;
    addr_n  = mem_addr;
    out_n   = io_out;
    err_n   = err;
    load_lo = 1'b0;
`ifdef QSPI_RESP_XIP_EN
    xip_n   = xip;
`endif
    if (csb) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      out_n   = 4'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = 4'd0;
          if (armed) begin
            cnt_n   = 4'd1;
            state_n = CMD;
`ifdef QSPI_RESP_XIP_EN
            if (xip) state_n = ADDR;
`endif
          end
        end
        CMD: begin
          if (cnt == 4'd7) begin
            cnt_n = 4'd0;
            if ({cmd_sh, io_in[0]} == CMD_QREAD) begin
              state_n = ADDR;
            end else begin
              state_n = IGNORE;
              err_n   = 1'b1;
            end
          end
        end
        ADDR: begin
          if (cnt == 4'd5) begin
            cnt_n   = 4'd0;
            state_n = MODE;
          end
        end
        MODE: begin
          if (cnt == 4'd1) begin
            cnt_n   = 4'd0;
            state_n = DUMMY;
`ifdef QSPI_RESP_XIP_EN
            xip_n   = (mode_bits == 2'b10);
`endif
            if (RD_IN_MODE) begin
              rd_n   = 1'b1;
              addr_n = addr_sh;
            end
          end
        end
        DUMMY: begin
          if (cnt == RD_CNT) begin
            rd_n   = 1'b1;
            addr_n = addr_sh;
          end
          if (cnt == DUMMY_LAST) begin
            cnt_n   = 4'd0;
            state_n = DATA;
            out_n   = mem_rdata[7:4];
            load_lo = 1'b1;
            rd_n    = 1'b1;
            addr_n  = mem_addr + 24'd1;
          end
        end
        DATA: begin
          // cnt[0] = 0: high nibble on the pins, next byte being fetched.
          cnt_n = {3'b000, ~cnt[0]};
          if (!cnt[0]) begin
            out_n = lo_q;
          end else begin
            out_n   = mem_rdata[7:4];
            load_lo = 1'b1;
            rd_n    = 1'b1;
            addr_n  = mem_addr + 24'd1;
          end
        end
        IGNORE: cnt_n = cnt;
        default: state_n = IDLE;
      endcase
    end
  end

  assign io_oe = {4{(state == DATA) && !csb}};
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb;
  logic [3:0]  io_in;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        err;

  qspi_flash_responder #(.DUMMY_CYCLES(DC), .CMD_QREAD(8'hEB)) dut (
    .clk(clk), .rst_n(rst_n), .csb(csb), .io_in(io_in), .io_out(io_out),
    .io_oe(io_oe), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  exp_nib_q[$];
  logic [23:0] exp_addr_q[$];
  logic [3:0]  rx_q[$];
  logic [7:0]  mem [int];
  bit          err_m = 1'b0;
  bit          xip_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Unwritten locations hold 01,23,45,67,89,AB,CD,EF repeating.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {a[2:0], 1'b0, a[2:0], 1'b1};
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_byte(mem_addr);

  // Monitor: outputs are sampled on the falling edge, before the driver moves.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (csb && io_oe != 4'h0) chk("oe_with_csb_high", {28'h0, io_oe}, 32'h0);
      if (io_oe == 4'hF) begin
        if (exp_nib_q.size() == 0) chk("unexpected_nibble", {28'h0, io_out}, 32'hFFFF_FFFF);
        else begin
          rx_q.push_back(io_out);
          chk("data_nibble", {28'h0, io_out}, {28'h0, exp_nib_q.pop_front()});
        end
      end else if (io_oe != 4'h0) chk("oe_split", {28'h0, io_oe}, 32'hF);
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) chk("unexpected_mem_rd", {8'h0, mem_addr}, 32'hFFFF_FFFF);
        else chk("mem_addr", {8'h0, mem_addr}, {8'h0, exp_addr_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic c, input logic [3:0] v);
    @(negedge clk);
    #1;
    csb   = c;
    io_in = v;
  endtask

  // One read transaction with the expected responses queued up front.
  task automatic qread(input logic [7:0] op, input logic [23:0] a, input logic [7:0] mode,
                       input int nbytes, input bit skip);
    bit accept;
    logic [7:0] b;
    accept = skip ? xip_m : (op == 8'hEB);
    if (accept) begin
      for (int k = 0; k <= nbytes; k++) exp_addr_q.push_back(a + 24'(k));
      for (int k = 0; k < nbytes; k++) begin
        b = mem_byte(a + 24'(k));
        exp_nib_q.push_back(b[7:4]);
        exp_nib_q.push_back(b[3:0]);
      end
    end else err_m = 1'b1;
    if (!skip) for (int i = 7; i >= 0; i--) drive(1'b0, {3'b000, op[i]});
    for (int i = 5; i >= 0; i--) drive(1'b0, a[i*4 +: 4]);
    drive(1'b0, mode[7:4]);
    drive(1'b0, mode[3:0]);
    repeat (DC) drive(1'b0, 4'h0);
    repeat (2 * nbytes - 1) drive(1'b0, 4'h0);
    repeat (3) drive(1'b1, 4'h0);
    chk("nibbles_left", exp_nib_q.size(), 0);
    chk("reads_left", exp_addr_q.size(), 0);
    chk("err_flag", {31'h0, err}, {31'h0, err_m});
`ifdef QSPI_RESP_XIP_EN
    if (accept) xip_m = (mode[5:4] == 2'b10);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    csb   = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    err_m = 1'b0;
    xip_m = 1'b0;
    drive(1'b1, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  wb [4];
    logic [23:0] ra;
    logic [7:0]  rop, rmode;
    int          rn;

    rst_n = 1'b0;
    csb   = 1'b1;
    io_in = 4'h0;
    #3;
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_io_oe", {28'h0, io_oe}, 32'h0);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    #20;
    rst_n = 1'b1;
    repeat (2) drive(1'b1, 4'h0);

    // Pattern store from address 0: nibbles 0..F twice.
    qread(8'hEB, 24'h000000, 8'h00, 16, 1'b0);

    // Reversed pattern at 0x10, assembled as little-endian 32-bit words.
    for (int k = 0; k < 16; k++) mem[16 + k] = 8'hEF - 8'((k % 8) * 8'h22);
    rx_q.delete();
    qread(8'hEB, 24'h000010, 8'h00, 16, 1'b0);
    chk("rx_count", rx_q.size(), 32);
    if (rx_q.size() == 32) begin
      for (int wi = 0; wi < 4; wi++) begin
        for (int bi = 0; bi < 4; bi++) wb[bi] = {rx_q[wi*8 + bi*2], rx_q[wi*8 + bi*2 + 1]};
        w = {wb[3], wb[2], wb[1], wb[0]};
        chk("word", w, (wi % 2 == 0) ? 32'h89AB_CDEF : 32'h0123_4567);
      end
    end

    // Address wrap at the top of the 24-bit space.
    qread(8'hEB, 24'hFFFFFF, 8'h00, 4, 1'b0);

    // csb rises for the 3rd address clock.
    for (int i = 7; i >= 0; i--) drive(1'b0, {3'b000, 8'hEB >> i} & 4'h1);
    drive(1'b0, 4'h1);
    drive(1'b0, 4'h2);
    drive(1'b1, 4'h3);
    @(posedge clk);
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (3) drive(1'b1, 4'h0);
    chk("abort_no_read", exp_addr_q.size(), 0);
    qread(8'hEB, 24'h000005, 8'h00, 3, 1'b0);

    // Reset in the middle of a transaction, released with csb still low.
    for (int i = 7; i >= 0; i--) drive(1'b0, {3'b000, 8'hEB >> i} & 4'h1);
    drive(1'b0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_oe", {28'h0, io_oe}, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    err_m = 1'b0;
    xip_m = 1'b0;
    for (int i = 7; i >= 0; i--) drive(1'b0, {3'b000, 8'hEB >> i} & 4'h1);
    repeat (4) drive(1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk("midrst_not_armed", {31'h0, busy}, 32'h0);
    repeat (2) drive(1'b1, 4'h0);
    qread(8'hEB, 24'h000000, 8'h00, 2, 1'b0);

    // Unsupported opcode, then a good read with err still set.
    qread(8'h03, 24'h000000, 8'h00, 2, 1'b0);
    qread(8'hEB, 24'h000008, 8'h00, 2, 1'b0);

    // XIP: mode A0, then an address-only transaction. Without XIP the io0
    // bits of 0x123456/00 read as 0xA8, which is rejected.
    do_reset();
    qread(8'hEB, 24'h000020, 8'hA0, 4, 1'b0);
    qread(8'h00, 24'h123456, 8'h00, 4, 1'b1);

    // Randomised reads; XIP continuation follows the model's flag.
    for (int t = 0; t < 10; t++) begin
      ra    = 24'($urandom);
      rn    = $urandom_range(1, 6);
      rmode = 8'($urandom);
      rop   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hEB;
      for (int k = 0; k <= rn; k++) mem[int'(ra + 24'(k))] = 8'($urandom);
      qread(rop, ra, rmode, rn, xip_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
